// File: rtl/axi_defs_pkg.sv
// rtl/axi_defs_pkg.sv - shared AXI constants and bridge state encoding
package axi_defs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_REQ,
        ST_WR_RESP
    } bridge_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [3:0] AXI_ID_DATA_RD = 4'd0;
    localparam logic [3:0] AXI_ID_DATA_WR = 4'd1;

    localparam logic [3:0] AXI_CACHE_WB = 4'b1111;
    localparam logic [3:0] AXI_CACHE_UC = 4'b0000;

    function automatic logic [3:0] axi_cache(input logic cached);
        return cached ? AXI_CACHE_WB : AXI_CACHE_UC;
    endfunction

endpackage

// File: rtl/data_sram_axi_bridge_if.sv
// rtl/data_sram_axi_bridge_if.sv - AXI3 channel bundle between bridge and slave
interface data_sram_axi_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [3:0]        arid;
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [3:0]        arcache;
    logic              arvalid;
    logic              arready;

    logic [3:0]        rid;
    logic [DATA_W-1:0] rdata_axi;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    logic [3:0]        awid;
    logic [ADDR_W-1:0] awaddr;
    logic [3:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic [3:0]        awcache;
    logic              awvalid;
    logic              awready;

    logic [3:0]        wid;
    logic [DATA_W-1:0] wdata_axi;
    logic [3:0]        wstrb_axi;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [3:0]        bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arcache, arvalid,
        input  arready,
        input  rid, rdata_axi, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
        input  awready,
        output wid, wdata_axi, wstrb_axi, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arcache, arvalid,
        output arready,
        output rid, rdata_axi, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
        output awready,
        input  wid, wdata_axi, wstrb_axi, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/data_sram_axi_bridge.sv
// rtl/data_sram_axi_bridge.sv - memory-stage req/addr_ok/data_ok to single-beat AXI3
module data_sram_axi_bridge
    import axi_defs_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        wstrb,
    input  logic [DATA_W-1:0] wdata,
    input  logic              cached,
    input  logic              flush,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [DATA_W-1:0] rdata,
    data_sram_axi_bridge_if.master axi
);

    bridge_state_t     state;
    logic              cancel;
    logic              aw_done;
    logic              w_done;

    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic [3:0]        wstrb_q;
    logic [DATA_W-1:0] wdata_q;
    logic              cached_q;
    logic              wr_q;

    logic              arvalid_q;
    logic              rready_q;
    logic              awvalid_q;
    logic              wvalid_q;
    logic              bready_q;

    logic accept;
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic aw_fin, w_fin;
    logic unused_axi_inputs;

    assign accept  = (state == ST_IDLE) && req && !flush;
    assign addr_ok = accept;

    assign ar_hs  = arvalid_q && axi.arready;
    assign r_hs   = rready_q  && axi.rvalid;
    assign aw_hs  = awvalid_q && axi.awready;
    assign w_hs   = wvalid_q  && axi.wready;
    assign b_hs   = bready_q  && axi.bvalid;
    assign aw_fin = aw_done || aw_hs;
    assign w_fin  = w_done  || w_hs;

    // Responses carry no error reporting; ids/resp/last are deliberately dropped.
    assign unused_axi_inputs = ^{axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp, wr_q};

    assign axi.arid      = AXI_ID_DATA_RD;
    assign axi.araddr    = addr_q;
    assign axi.arlen     = 4'd0;
    assign axi.arsize    = {1'b0, size_q};
    assign axi.arburst   = AXI_BURST_INCR;
    assign axi.arcache   = axi_cache(cached_q);
    assign axi.arvalid   = arvalid_q;
    assign axi.rready    = rready_q;

    assign axi.awid      = AXI_ID_DATA_WR;
    assign axi.awaddr    = addr_q;
    assign axi.awlen     = 4'd0;
    assign axi.awsize    = {1'b0, size_q};
    assign axi.awburst   = AXI_BURST_INCR;
    assign axi.awcache   = axi_cache(cached_q);
    assign axi.awvalid   = awvalid_q;

    assign axi.wid       = AXI_ID_DATA_WR;
    assign axi.wdata_axi = wdata_q;
    assign axi.wstrb_axi = wstrb_q;
    assign axi.wlast     = 1'b1;
    assign axi.wvalid    = wvalid_q;
    assign axi.bready    = bready_q;

    // Bridge FSM: request latch, AXI valid/ready generation, cancel tracking, data_ok pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cancel    <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            addr_q    <= '0;
            size_q    <= '0;
            wstrb_q   <= '0;
            wdata_q   <= '0;
            cached_q  <= 1'b0;
            wr_q      <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            data_ok   <= 1'b0;
            rdata     <= '0;
        end else begin
            data_ok <= 1'b0;
            // A flush mid-transaction only marks it; the AXI side must still finish.
            if (flush && state != ST_IDLE) begin
                cancel <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q   <= addr;
                        size_q   <= size;
                        wstrb_q  <= wstrb;
                        wdata_q  <= wdata;
                        cached_q <= cached;
                        wr_q     <= wr;
                        if (wr) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= ST_WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= ST_RD_ADDR;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (r_hs) begin
                        rready_q <= 1'b0;
                        rdata    <= axi.rdata_axi;
                        data_ok  <= !(cancel || flush);
                        cancel   <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                ST_WR_REQ: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                        bready_q <= 1'b1;
                        state    <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (b_hs) begin
                        bready_q <= 1'b0;
                        data_ok  <= !(cancel || flush);
                        cancel   <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_axi_bridge.sv
// tb/tb_data_sram_axi_bridge.sv - directed self-checking bench for data_sram_axi_bridge
module tb_data_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        cached;
    logic        flush;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    int total = 0;
    int bad   = 0;
    int pulses;

    data_sram_axi_bridge_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    data_sram_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .wr      (wr),
        .size    (size),
        .addr    (addr),
        .wstrb   (wstrb),
        .wdata   (wdata),
        .cached  (cached),
        .flush   (flush),
        .addr_ok (addr_ok),
        .data_ok (data_ok),
        .rdata   (rdata),
        .axi     (axi.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic w, input logic [1:0] sz, input logic [31:0] a,
                           input logic [3:0] st, input logic [31:0] d, input logic c);
        req = 1'b1; wr = w; size = sz; addr = a; wstrb = st; wdata = d; cached = c;
    endtask

    initial begin
        rst = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd0; addr = '0; wstrb = '0;
        wdata = '0; cached = 1'b0; flush = 1'b0;
        axi.arready = 1'b0; axi.rid = 4'd0; axi.rdata_axi = '0; axi.rresp = 2'd0;
        axi.rlast = 1'b1; axi.rvalid = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
        axi.bid = 4'd1; axi.bresp = 2'd0; axi.bvalid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rst_arvalid", axi.arvalid, 1'b0);
        check("rst_awvalid", axi.awvalid, 1'b0);
        check("rst_wvalid",  axi.wvalid,  1'b0);
        check("rst_rready",  axi.rready,  1'b0);
        check("rst_bready",  axi.bready,  1'b0);
        check("rst_data_ok", data_ok,     1'b0);
        check("rst_rdata",   rdata,       32'h0);
        check("rst_addr_ok", addr_ok,     1'b0);

        // Read word, zero-wait slave
        tick();
        axi.arready = 1'b1; axi.rvalid = 1'b1; axi.rdata_axi = 32'h1234_5678;
        set_req(1'b0, 2'd2, 32'h8000_0010, 4'hf, 32'h0, 1'b1);
        #1;
        check("rd_addr_ok_T", addr_ok, 1'b1);
        tick();
        req = 1'b0;
        check("rd_arvalid_T1", axi.arvalid, 1'b1);
        check("rd_araddr",     axi.araddr,  32'h8000_0010);
        check("rd_arsize",     axi.arsize,  3'd2);
        check("rd_arcache",    axi.arcache, 4'hf);
        check("rd_arid",       axi.arid,    4'd0);
        check("rd_arlen",      axi.arlen,   4'd0);
        check("rd_arburst",    axi.arburst, 2'b01);
        tick();
        check("rd_rready_T2",  axi.rready,  1'b1);
        check("rd_arvalid_T2", axi.arvalid, 1'b0);
        check("rd_dok_T2",     data_ok,     1'b0);
        check("rd_rdata_T2",   rdata,       32'h0);
        tick();
        check("rd_dok_T3",     data_ok,     1'b1);
        check("rd_rdata_T3",   rdata,       32'h1234_5678);
        axi.arready = 1'b0; axi.rvalid = 1'b0;
        tick();
        check("rd_dok_T4",     data_ok,     1'b0);
        check("rd_rdata_hold", rdata,       32'h1234_5678);

        // Write byte, awready delayed 3 cycles, wready immediate
        axi.wready = 1'b1;
        set_req(1'b1, 2'd0, 32'hBFAF_0002, 4'b0100, 32'hAABB_CCDD, 1'b0);
        #1;
        check("wr_addr_ok_T", addr_ok, 1'b1);
        tick();
        req = 1'b0;
        check("wr_awvalid_T1", axi.awvalid,   1'b1);
        check("wr_wvalid_T1",  axi.wvalid,    1'b1);
        check("wr_awsize",     axi.awsize,    3'd0);
        check("wr_awaddr",     axi.awaddr,    32'hBFAF_0002);
        check("wr_wstrb",      axi.wstrb_axi, 4'b0100);
        check("wr_wdata",      axi.wdata_axi, 32'hAABB_CCDD);
        check("wr_awcache",    axi.awcache,   4'h0);
        check("wr_awid",       axi.awid,      4'd1);
        check("wr_wid",        axi.wid,       4'd1);
        check("wr_wlast",      axi.wlast,     1'b1);
        tick();
        check("wr_wvalid_T2",  axi.wvalid,    1'b0);
        check("wr_awvalid_T2", axi.awvalid,   1'b1);
        tick();
        check("wr_awvalid_T3", axi.awvalid,   1'b1);
        check("wr_bready_T3",  axi.bready,    1'b0);
        tick();
        check("wr_awvalid_T4", axi.awvalid,   1'b1);
        axi.awready = 1'b1;
        tick();
        axi.awready = 1'b0;
        check("wr_awvalid_T5", axi.awvalid,   1'b0);
        check("wr_bready_T5",  axi.bready,    1'b1);
        check("wr_dok_T5",     data_ok,       1'b0);
        tick();
        axi.bvalid = 1'b1;
        tick();
        axi.bvalid = 1'b0;
        check("wr_dok_after_b", data_ok,      1'b1);
        check("wr_bready_done", axi.bready,   1'b0);
        tick();
        check("wr_dok_pulse",   data_ok,      1'b0);
        check("wr_rdata_hold",  rdata,        32'h1234_5678);

        // Flush while in RD_DATA: read completes on AXI, no data_ok
        axi.arready = 1'b1;
        set_req(1'b0, 2'd2, 32'h0000_0100, 4'hf, 32'h0, 1'b1);
        tick();
        req = 1'b0;
        tick();
        check("fl_rready", axi.rready, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_rready_held", axi.rready, 1'b1);
        tick();
        axi.rvalid = 1'b1; axi.rdata_axi = 32'hDEAD_BEEF;
        tick();
        axi.rvalid = 1'b0;
        check("fl_no_dok",  data_ok,    1'b0);
        check("fl_rready0", axi.rready, 1'b0);
        check("fl_rdata",   rdata,      32'hDEAD_BEEF);
        set_req(1'b0, 2'd2, 32'h0000_0104, 4'hf, 32'h0, 1'b1);
        axi.rvalid = 1'b1; axi.rdata_axi = 32'h0BAD_F00D;
        #1;
        check("fl_next_addr_ok", addr_ok, 1'b1);
        tick();
        req = 1'b0;
        tick();
        tick();
        check("fl_next_dok",   data_ok, 1'b1);
        check("fl_next_rdata", rdata,   32'h0BAD_F00D);
        axi.rvalid = 1'b0; axi.arready = 1'b0;
        tick();

        // req with flush in IDLE is not accepted
        set_req(1'b1, 2'd2, 32'h0000_0200, 4'hf, 32'h1, 1'b0);
        flush = 1'b1;
        #1;
        check("idle_flush_addr_ok", addr_ok, 1'b0);
        tick();
        req = 1'b0; flush = 1'b0;
        check("idle_flush_arvalid", axi.arvalid, 1'b0);
        check("idle_flush_awvalid", axi.awvalid, 1'b0);
        check("idle_flush_wvalid",  axi.wvalid,  1'b0);

        // Back-to-back read then write, zero-wait slave
        axi.arready = 1'b1; axi.rvalid = 1'b1; axi.rdata_axi = 32'h55AA_55AA;
        axi.awready = 1'b1; axi.wready = 1'b1; axi.bvalid = 1'b1;
        set_req(1'b0, 2'd2, 32'h0000_0300, 4'hf, 32'h0, 1'b1);
        #1;
        check("b2b_addr_ok1", addr_ok, 1'b1);
        pulses = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (data_ok) pulses++;
            if (c == 3) begin
                check("b2b_dok1", data_ok, 1'b1);
                set_req(1'b1, 2'd2, 32'h0000_0304, 4'hf, 32'hCAFE_0001, 1'b1);
                #1;
                check("b2b_addr_ok2", addr_ok, 1'b1);
            end else begin
                req = 1'b0;
            end
            if (c == 6) check("b2b_dok2", data_ok, 1'b1);
        end
        check("b2b_pulses", pulses, 2);
        check("b2b_rdata",  rdata,  32'h55AA_55AA);
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.bvalid = 1'b0;

        // Reset during WR_RESP
        set_req(1'b1, 2'd2, 32'h0000_0400, 4'hf, 32'h1111_2222, 1'b0);
        tick();
        req = 1'b0;
        tick();
        check("rw_bready", axi.bready, 1'b1);
        rst = 1'b0;
        tick();
        check("rw_arvalid", axi.arvalid, 1'b0);
        check("rw_awvalid", axi.awvalid, 1'b0);
        check("rw_wvalid",  axi.wvalid,  1'b0);
        check("rw_rready",  axi.rready,  1'b0);
        check("rw_bready0", axi.bready,  1'b0);
        check("rw_data_ok", data_ok,     1'b0);
        rst = 1'b1;
        set_req(1'b0, 2'd2, 32'h0000_0500, 4'hf, 32'h0, 1'b0);
        #1;
        check("rw_idle_addr_ok", addr_ok, 1'b1);
        req = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
